dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the data-memory request interface driven by the pipeline's MEM stage. Accepts one word read or write per handshake, performs it on an internal word array, and returns a single-cycle response after a fixed, parameterised latency. Replaces the zero-wait data memory so the pipeline can be exercised against a multi-cycle memory. While a request is outstanding, `req_ready` is low, and the pipeline treats that as a stall.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words in the array; must be a power of two.
- `LATENCY`, 2: cycles from request acceptance to response; legal range is 1 to 15.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: responder can accept a request this cycle.
- `req_we`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, 32: byte address (the ALU result).
- `req_wdata`, in, 32: write data (the forwarded rt value).
- `rsp_valid`, out, 1: one-cycle response pulse.
- `rsp_rdata`, out, 32: read data; 0 for writes and errors.
- `rsp_err`, out, 1: request was misaligned or out of range.

## Operation
- **Handshake:** a request is accepted at the rising edge where `req_valid && req_ready`. At most one request is outstanding. `rsp_valid` has no backpressure; the requester must take it in the pulse cycle.
- **Address decode:**
  - word index = `req_addr[31:2]`.
  - Error if `req_addr[1:0] != 0`, or if the word index is ≥ `DEPTH`.
- **Error requests:** no array access is made; the response carries `rsp_err=1` and `rsp_rdata=0`.
- **Write:** the array is updated at the acceptance edge. The response carries `rsp_err=0` and `rsp_rdata=0`.
- **Read:** the word is captured at the acceptance edge into a holding register and presented with the response.
- **FSM states:**
  - IDLE: `req_ready=1`. On acceptance, `cnt` loads `LATENCY-1`. If `LATENCY==1`, go to RESP; otherwise go to WAIT.
  - WAIT: `req_ready=0` and `cnt` decrements. When `cnt` reaches 1, go to RESP.
  - RESP: `rsp_valid=1` and `req_ready=1`. On a new acceptance, reload per the IDLE rule (back-to-back). Otherwise go to IDLE.
- **Counter:** 4-bit down counter; it never wraps below 0.
- **Reset mid-operation:** any pending response is discarded and no late `rsp_valid` is produced. A write accepted before reset stays committed.
- **Array contents:** not cleared by reset.

## Timing
- **Reset values:** `req_ready=0` during the reset cycle and 1 in the first cycle after reset. `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`. State = IDLE.
- **Latency:** a request accepted at the end of cycle n produces `rsp_valid` high during cycle n+LATENCY, for exactly one cycle.
- **Ready window:** `req_ready` is low in cycles n+1 through n+LATENCY-1 and high in cycle n+LATENCY. Sustained throughput is therefore one request per `LATENCY` cycles.
- **`LATENCY==1`:** `req_ready` is permanently high after reset, giving one request per cycle.
- **Output registers:** `rsp_rdata` and `rsp_err` are registered and are valid only while `rsp_valid` is high. They are driven to 0 when `rsp_valid` is low.
- **Write-then-read to the same word:** a read accepted in the cycle after a write's acceptance returns the new data.

## Structure
- **Package `dmem_pkg`:**
  - state enum {IDLE, WAIT, RESP}.
  - `WORD_W=32`.
  - Function `addr_err(addr, depth)`.
- **Sub-module `dmem_array`:**
  - Single-port word RAM with write enable, synchronous write and combinational read.
  - The responder registers the read word at acceptance.
- **Top-level content:** FSM, counter, decode and response registers.

## Test plan
1. **Basic write then read:** reset, `LATENCY=2`. Write `0xDEADBEEF` to byte address `0x10`. Then read `0x10`.
   - Write: `rsp_valid` 2 cycles after acceptance, `rsp_err=0`, `rsp_rdata=0`.
   - Read: returns `0xDEADBEEF` 2 cycles after acceptance.
   - `req_ready` is low for exactly 1 cycle per request.
2. **Back-to-back reads:** `LATENCY=3`, `req_valid` held high for 4 reads of preloaded addresses 0, 4, 8, 12.
   - Responses arrive every 3 cycles.
   - Each new acceptance coincides with the previous `rsp_valid` cycle.
   - Data returns in order.
3. **Single-cycle latency:** `LATENCY=1`, writes to addresses 0..7 words on consecutive cycles, then reads of the same addresses.
   - `req_ready` stays 1 throughout.
   - One response per cycle, each with its matching data.
4. **Error responses:**
   - Read `0x13` (misaligned): `rsp_err=1`, `rsp_rdata=0`.
   - Write `4*DEPTH` (out of range): `rsp_err=1`, and the array is unchanged at word 0.
5. **Reset mid-operation:** `LATENCY=4`, accept a read, assert `reset` 2 cycles later.
   - No `rsp_valid` appears.
   - After reset, `req_ready=1` and all outputs are 0.
   - A write accepted before the reset is still readable afterwards.
6. **Write-then-read hazard:** write `0x1234` to address `0x40`; accept a read of `0x40` in the first cycle `req_ready` returns.
   - The read returns `0x1234`, not the prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
// Holds the FSM state encoding, the word width and the address-error decode.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Misaligned byte address, or word index beyond the end of the array.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
        logic [WORD_W-1:0] word_idx;
        word_idx = {2'b00, addr[WORD_W-1:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, combinational read on the same address.
// Contents are deliberately not cleared by reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the MEM-stage data-memory interface: one outstanding word access,
// answered with a single-cycle response pulse a fixed LATENCY cycles after acceptance.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              req_err;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [WORD_W-1:0] ram_rdata;

    assign req_err  = addr_err(req_addr, DEPTH);
    assign ram_addr = req_addr[AW+1:2];

    // Ready is held low during the reset cycle so nothing can be accepted across it.
    assign req_ready = !reset && (state_q != WAIT);
    assign accept    = req_valid && req_ready;
    assign ram_we    = accept && req_we && !req_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                    rdata_d = (!req_we && !req_err) ? ram_rdata : '0;
                    err_d   = req_err;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = (cnt_q != '0) ? cnt_q - 4'd1 : '0;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Response fields are forced to zero outside the pulse.
    assign rsp_valid = !reset && (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances at latencies 2, 3, 1 and 4 share one
// request bus; only the selected instance sees req_valid. Responses are scoreboarded.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int LAT [4] = '{2, 3, 1, 4};

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    int          sel = 0;

    logic [3:0]  vld;
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic [3:0]  re;
    logic [31:0] rd [4];

    int          cyc = 0;
    int          total = 0;
    int          fails = 0;
    int          acc_cyc = 0;
    exp_t        q[$];
    logic [31:0] model [4][64];
    vec_t        vt [22];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign vld[0] = req_valid && (sel == 0);
    assign vld[1] = req_valid && (sel == 1);
    assign vld[2] = req_valid && (sel == 2);
    assign vld[3] = req_valid && (sel == 3);

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
        .rsp_err(re[0])
    );
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
        .rsp_err(re[1])
    );
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[2]), .rsp_rdata(rd[2]),
        .rsp_err(re[2])
    );
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(vld[3]), .req_ready(rdy[3]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[3]), .rsp_rdata(rd[3]),
        .rsp_err(re[3])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (dut %0d, cycle %0d): got %h expected %h", name, sel, cyc, act, exp);
        end
    endtask

    function automatic logic calc_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
    endfunction

    // Scoreboard: pops on every response pulse of the selected instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (rv[sel]) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp_valid", 32'(rv[sel]), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_rdata", rd[sel], e.rd);
                    chk("rsp_err", 32'(re[sel]), 32'(e.err));
                end
            end else begin
                chk("idle_rdata_zero", rd[sel], 32'd0);
                chk("idle_err_zero", 32'(re[sel]), 32'd0);
            end
            if (sel == 2) begin
                chk("lat1_ready_high", 32'(rdy[2]), 32'd1);
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input bit push);
        bit done;
        done      = 1'b0;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (rdy[sel]) begin
                acc_cyc = cyc;
                done    = 1'b1;
                if (push) q.push_back('{cyc + LAT[sel], exp_rd, exp_err});
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic e;
        e = calc_err(addr);
        if (!e) model[sel][addr[7:2]] = data;
        issue(1'b1, addr, data, 32'd0, e, 1'b1);
    endtask

    task automatic rdq(input logic [31:0] addr, input bit push);
        logic e;
        e = calc_err(addr);
        issue(1'b0, addr, 32'd0, e ? 32'd0 : model[sel][addr[7:2]], e, push);
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clk);
        if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_gap(input string name);
        int low;
        bit seen;
        low  = 0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (rdy[sel]) seen = 1'b1;
            else low++;
        end
        chk(name, low, LAT[sel] - 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int prev;

        // Table for the single-cycle instance: 8 writes, 8 reads, errors, hazard.
        for (int i = 0; i < 8; i++) begin
            vt[i]     = '{1'b1, 32'(4 * i), 32'h100 + 32'(i), 32'd0, 1'b0};
            vt[i + 8] = '{1'b0, 32'(4 * i), 32'd0, 32'h100 + 32'(i), 1'b0};
        end
        vt[16] = '{1'b0, 32'h13, 32'd0, 32'd0, 1'b1};
        vt[17] = '{1'b1, 32'(4 * DEPTH), 32'hBAD0BAD0, 32'd0, 1'b1};
        vt[18] = '{1'b0, 32'h0, 32'd0, 32'h100, 1'b0};
        vt[19] = '{1'b1, 32'h40, 32'h77, 32'd0, 1'b0};
        vt[20] = '{1'b0, 32'h40, 32'd0, 32'h77, 1'b0};
        vt[21] = '{1'b1, 32'h12, 32'h55, 32'd0, 1'b1};

        // Reset values
        @(posedge clk); #1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            sel = k;
            chk("ready_in_reset", 32'(rdy[k]), 32'd0);
        end
        sel = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            sel = k;
            chk("reset_ready", 32'(rdy[k]), 32'd1);
            chk("reset_rsp_valid", 32'(rv[k]), 32'd0);
            chk("reset_rdata", rd[k], 32'd0);
            chk("reset_err", 32'(re[k]), 32'd0);
        end
        @(posedge clk); #1;

        // Basic write then read, LATENCY=2
        sel = 0;
        wr(32'h10, 32'hDEADBEEF);
        check_gap("lat2_write_ready_gap");
        rdq(32'h10, 1'b1);
        check_gap("lat2_read_ready_gap");
        drain();
        rdq(32'h13, 1'b1);
        drain();

        // Back-to-back reads, LATENCY=3
        sel = 1;
        for (int i = 0; i < 4; i++) wr(32'(4 * i), 32'hC0DE0000 + 32'(i * 17));
        drain();
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            rdq(32'(4 * i), 1'b1);
            if (i > 0) chk("lat3_accept_spacing", acc_cyc - prev, 32'd3);
            prev = acc_cyc;
        end
        drain();

        // Single-cycle latency and error responses from the table
        sel = 2;
        prev = 0;
        for (int i = 0; i < 22; i++) begin
            issue(vt[i].we, vt[i].addr, vt[i].wd, vt[i].exp_rd, vt[i].exp_err, 1'b1);
            if (i > 0) chk("lat1_accept_spacing", acc_cyc - prev, 32'd1);
            prev = acc_cyc;
        end
        drain();

        // Write-then-read hazard, LATENCY=2
        sel = 0;
        wr(32'h40, 32'h5555);
        drain();
        wr(32'h40, 32'h1234);
        prev = acc_cyc;
        rdq(32'h40, 1'b1);
        chk("hazard_accept_spacing", acc_cyc - prev, 32'd2);
        drain();

        // Reset mid-operation, LATENCY=4
        sel = 3;
        wr(32'h20, 32'hA5A50001);
        drain();
        rdq(32'h20, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_ready_low", 32'(rdy[3]), 32'd0);
        chk("midreset_rsp_valid", 32'(rv[3]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("postreset_ready", 32'(rdy[3]), 32'd1);
        chk("postreset_rsp_valid", 32'(rv[3]), 32'd0);
        chk("postreset_rdata", rd[3], 32'd0);
        chk("postreset_err", 32'(re[3]), 32'd0);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        rdq(32'h20, 1'b1);
        drain();
        sel = 0;
        rdq(32'h10, 1'b1);
        drain();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
